// File: rtl/gate_demo_sequencer_if.sv
// gate_demo_sequencer_if: board-side switch, button, gate datapath and LED signals of the sequencer.
interface gate_demo_sequencer_if;
    logic       I_P_SW_A;
    logic       I_P_SW_B;
    logic       I_P_BTN_MODE;
    logic       I_P_BTN_STEP;
    logic [1:0] I_P_GATE_SEL;
    logic       I_P_GATE_Y;
    logic       O_P_GATE_A;
    logic       O_P_GATE_B;
    logic       O_P_LED_A;
    logic       O_P_LED_B;
    logic       O_P_LED_GATE;
    logic [1:0] O_P_LED_MODE;
    logic       O_P_LED_ERR;
    modport master (
        output I_P_SW_A, I_P_SW_B, I_P_BTN_MODE, I_P_BTN_STEP, I_P_GATE_SEL, I_P_GATE_Y,
        input  O_P_GATE_A, O_P_GATE_B, O_P_LED_A, O_P_LED_B, O_P_LED_GATE, O_P_LED_MODE, O_P_LED_ERR
    );
    modport slave (
        input  I_P_SW_A, I_P_SW_B, I_P_BTN_MODE, I_P_BTN_STEP, I_P_GATE_SEL, I_P_GATE_Y,
        output O_P_GATE_A, O_P_GATE_B, O_P_LED_A, O_P_LED_B, O_P_LED_GATE, O_P_LED_MODE, O_P_LED_ERR
    );
endinterface

// File: rtl/gate_demo_sequencer.sv
// gate_demo_sequencer: MANUAL/STEP/AUTO operand sequencer for a two-input gate datapath with LED mirror.
// Define GATE_SELF_CHECK_EN to compare the returned gate result against a golden truth table.
module gate_demo_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_CYCLES     = 100000000
) (
    input  logic                 I_P_CLK,
    input  logic                 I_P_RST,
    gate_demo_sequencer_if.slave io
);
    localparam logic [1:0] MANUAL = 2'b00;
    localparam logic [1:0] STEP   = 2'b01;
    localparam logic [1:0] AUTO   = 2'b10;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(STEP_CYCLES + 1);

    // bit map: [5:4] gate_sel, [3] btn_step, [2] btn_mode, [1] sw_a, [0] sw_b
    logic [5:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]          lvl_q, lvl_d, prev_q, prev_d;
    logic [1:0][DW-1:0]  cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d, row_q, row_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                gate_a_q, gate_a_d, gate_b_q, gate_b_d;
    logic [1:0]          btn_s, press;
    logic                mode_p, step_p, tc;

    assign btn_s  = sync2_q[3:2];
    assign press  = lvl_q & ~prev_q;
    assign mode_p = press[0];
    assign step_p = press[1];
    assign tc     = presc_q == PW'(STEP_CYCLES - 1);

    always_comb begin
        sync1_d = {io.I_P_GATE_SEL, io.I_P_BTN_STEP, io.I_P_BTN_MODE, io.I_P_SW_A, io.I_P_SW_B};
        sync2_d = sync1_q;
        prev_d  = lvl_q;
        lvl_d   = lvl_q;
        cnt_d   = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = (btn_s[i] != lvl_q[i]) ? cnt_q[i] + 1'b1 : '0;
            if (btn_s[i] != lvl_q[i] && cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d[i] = btn_s[i];
                cnt_d[i] = '0;
            end
        end
        // a mode pulse wins over a coincident step pulse or terminal count
        mode_d  = mode_p ? ((mode_q == MANUAL) ? STEP : (mode_q == STEP) ? AUTO : MANUAL)
                         : ((mode_q == 2'b11) ? MANUAL : mode_q);
        row_d   = mode_p ? (mode_q[1] ? row_q : 2'b00)
                         : row_q + {1'b0, (mode_q == STEP) ? step_p : ((mode_q == AUTO) & tc)};
        presc_d = (mode_p || mode_q != AUTO || tc) ? '0 : presc_q + 1'b1;
        {gate_a_d, gate_b_d} = (mode_q == MANUAL) ? sync2_q[1:0] : row_q;
    end

    always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
        if (I_P_RST) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= MANUAL;
            row_q    <= '0;
            presc_q  <= '0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            lvl_q    <= lvl_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            row_q    <= row_d;
            presc_q  <= presc_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
        end
    end

    assign io.O_P_GATE_A   = gate_a_q;
    assign io.O_P_GATE_B   = gate_b_q;
    assign io.O_P_LED_A    = gate_a_q;
    assign io.O_P_LED_B    = gate_b_q;
    assign io.O_P_LED_GATE = io.I_P_GATE_Y;
    assign io.O_P_LED_MODE = mode_q;

`ifdef GATE_SELF_CHECK_EN
    logic [3:0] hist_q, hist_d;
    logic       err_q, err_d, golden, settled;

    always_comb begin
        hist_d  = {sync2_q[5:4], gate_a_q, gate_b_q};
        settled = hist_d == hist_q;
        golden  = (sync2_q[5:4] == 2'b00) ? (gate_a_q & gate_b_q) :
                  (sync2_q[5:4] == 2'b01) ? (gate_a_q | gate_b_q) :
                  (sync2_q[5:4] == 2'b10) ? (gate_a_q ^ gate_b_q) : ~(gate_a_q & gate_b_q);
        err_d   = mode_p ? 1'b0 : err_q | (settled & (golden != io.I_P_GATE_Y));
    end

    always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
        if (I_P_RST) begin
            hist_q <= '0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            err_q  <= err_d;
        end
    end

    assign io.O_P_LED_ERR = err_q;
`else
    logic unused_sel;
    assign unused_sel     = ^sync2_q[5:4];
    assign io.O_P_LED_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_gate_demo_sequencer.sv
// tb_gate_demo_sequencer: scoreboard bench; stimulus queues expected output changes, a monitor pops them.
module tb_gate_demo_sequencer;
    typedef struct {
        logic [4:0] val;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic force_zero;
    bit   done;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    gate_demo_sequencer_if bus();

    gate_demo_sequencer #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(8)) dut (
        .I_P_CLK(clk),
        .I_P_RST(rst),
        .io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // XOR datapath (GATE_SEL stays 10), optionally stuck at 0
    assign bus.I_P_GATE_Y = force_zero ? 1'b0 : (bus.O_P_GATE_A ^ bus.O_P_GATE_B);

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push(input logic [1:0] m, input logic a, input logic b, input logic e, input int c);
        exp_t x;
        x.val = {m, a, b, e};
        x.cyc = c;
        q.push_back(x);
    endtask

    task automatic press(input bit step, input int hold);
        if (step) bus.I_P_BTN_STEP = 1'b1;
        else bus.I_P_BTN_MODE = 1'b1;
        tick(hold);
        bus.I_P_BTN_STEP = 1'b0;
        bus.I_P_BTN_MODE = 1'b0;
        tick(10);
    endtask

    initial begin
        int n, e;
        logic [1:0] r;
        rst = 1'b1;
        force_zero = 1'b0;
        done = 1'b0;
        bus.I_P_SW_A = 1'b0;
        bus.I_P_SW_B = 1'b0;
        bus.I_P_BTN_MODE = 1'b0;
        bus.I_P_BTN_STEP = 1'b0;
        bus.I_P_GATE_SEL = 2'b10;
        push(2'b00, 0, 0, 0, -1);
        tick(3);
        rst = 1'b0;
        tick(2);
        // MANUAL path
        n = cyc; bus.I_P_SW_A = 1'b1; push(2'b00, 1, 0, 0, n + 3); tick(6);
        n = cyc; bus.I_P_SW_A = 1'b0; push(2'b00, 0, 0, 0, n + 3); tick(6);
        n = cyc; bus.I_P_SW_B = 1'b1; push(2'b00, 0, 1, 0, n + 3); tick(6);
        n = cyc; bus.I_P_SW_B = 1'b0; push(2'b00, 0, 0, 0, n + 3); tick(6);
        // step press in MANUAL: no visible change
        press(1'b1, 8);
        // bounce rejection, then one clean hold
        for (int i = 0; i < 3; i++) begin
            bus.I_P_BTN_MODE = 1'b1; tick(3);
            bus.I_P_BTN_MODE = 1'b0; tick(3);
        end
        n = cyc; push(2'b01, 0, 0, 0, n + 7);
        press(1'b0, 10);
        // STEP sequencing
        r = 2'b00;
        for (int i = 0; i < 5; i++) begin
            r = r + 2'b01;
            n = cyc; push(2'b01, r[1], r[0], 0, n + 8);
            press(1'b1, 8);
        end
        // AUTO wrap, then a mode press landing on the terminal count
        n = cyc; e = n + 7;
        push(2'b10, 0, 1, 0, n + 7);
        push(2'b10, 0, 0, 0, n + 8);
        push(2'b10, 0, 1, 0, e + 9);
        push(2'b10, 1, 0, 0, e + 17);
        push(2'b10, 1, 1, 0, e + 25);
        push(2'b10, 0, 0, 0, e + 33);
        push(2'b00, 0, 0, 0, e + 40);
        press(1'b0, 8);
        wait_until(e + 33);
        press(1'b0, 8);
        // into STEP, advance to operands 01 (stuck-at-0 result when self-check is built in)
`ifdef GATE_SELF_CHECK_EN
        force_zero = 1'b1;
`endif
        n = cyc; push(2'b01, 0, 0, 0, n + 7);
        press(1'b0, 8);
        n = cyc; push(2'b01, 0, 1, 0, n + 8);
`ifdef GATE_SELF_CHECK_EN
        push(2'b01, 0, 1, 1, n + 10);
`endif
        press(1'b1, 8);
        force_zero = 1'b0;
        tick(4);
        // mode press clears the error flag; reset lands mid-AUTO at row 10
        n = cyc; e = n + 7;
        push(2'b10, 0, 1, 0, n + 7);
        push(2'b10, 0, 0, 0, n + 8);
        push(2'b10, 0, 1, 0, e + 9);
        push(2'b10, 1, 0, 0, e + 17);
        push(2'b00, 0, 0, 0, e + 20);
        press(1'b0, 8);
        wait_until(e + 20);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        // restart in MANUAL, then the first mode press goes to STEP
        n = cyc; bus.I_P_SW_A = 1'b1; push(2'b00, 1, 0, 0, n + 3); tick(6);
        n = cyc;
        push(2'b01, 1, 0, 0, n + 7);
        push(2'b01, 0, 0, 0, n + 8);
        press(1'b0, 8);
        tick(5);
        done = 1'b1;
    end

    initial begin
        bit first = 1'b1;
        logic [4:0] prev, cur;
        exp_t x;
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL timeout: stimulus not done by cycle %0d, required done before 3000", cyc);
                break;
            end
            cur = {bus.O_P_LED_MODE, bus.O_P_GATE_A, bus.O_P_GATE_B, bus.O_P_LED_ERR};
            if (first || cur !== prev) begin
                first = 1'b0;
                prev = cur;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got mode/a/b/err=%b at cyc %0d, required no change", cur, cyc);
                end else begin
                    x = q.pop_front();
                    if (cur !== x.val || (x.cyc >= 0 && x.cyc != cyc) ||
                        bus.O_P_LED_A !== bus.O_P_GATE_A || bus.O_P_LED_B !== bus.O_P_GATE_B ||
                        bus.O_P_LED_GATE !== bus.I_P_GATE_Y) begin
                        errors++;
                        $display("FAIL output_event: got mode/a/b/err=%b led_ab=%b%b led_gate=%b y=%b at cyc %0d, required %b at cyc %0d",
                                 cur, bus.O_P_LED_A, bus.O_P_LED_B, bus.O_P_LED_GATE, bus.I_P_GATE_Y, cyc, x.val, x.cyc);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d expected changes never seen, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
